dpr_copy_engine: RTL and testbench

//  Block-copy initiator for the true dual-port RAM (True_DPR). Reads a word

---
 rtl/dpr_copy_engine_pkg.sv | 16 +
 rtl/dpr_copy_engine_addr_gen.sv | 40 ++++
 rtl/dpr_copy_engine.sv | 146 ++++++++++++++
 tb/tb_dpr_copy_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpr_copy_engine_pkg.sv
// Shared definitions for the dual-port RAM copy engine:
// default geometry and FSM state encoding.
package dpr_copy_engine_pkg;

    localparam int DPR_ADDR_SIZE = 8;
    localparam int DPR_DATA_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_LAST = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } dpr_state_t;

endpackage

// File: rtl/dpr_copy_engine_addr_gen.sv
// Loadable up/down word-address counter with remaining-count tracking;
// last is high while the final address of the range is presented.
module dpr_copy_engine_addr_gen
    import dpr_copy_engine_pkg::*;
#(
    parameter int ADDR_SIZE = DPR_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 down,
    input  logic [ADDR_SIZE-1:0] first_addr,
    input  logic [ADDR_SIZE:0]   count,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 last
);

    logic [ADDR_SIZE:0] remaining;
    logic               dir_down;

    // Stepping stops on the last word so the address never wraps past the range.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            dir_down  <= 1'b0;
        end else if (load) begin
            addr      <= first_addr;
            remaining <= count;
            dir_down  <= down;
        end else if (step && !last) begin
            addr      <= dir_down ? addr - ADDR_SIZE'(1) : addr + ADDR_SIZE'(1);
            remaining <= remaining - (ADDR_SIZE+1)'(1);
        end
    end

    assign last = (remaining == (ADDR_SIZE+1)'(1));

endmodule

// File: rtl/dpr_copy_engine.sv
// Block-copy initiator for a true dual-port RAM: reads a word range through
// port A and writes it through port B at one word per cycle.
module dpr_copy_engine
    import dpr_copy_engine_pkg::*;
#(
    parameter int ADDR_SIZE = DPR_ADDR_SIZE,
    parameter int DATA_SIZE = DPR_DATA_SIZE,
    parameter int RAM_SIZE  = 1 << ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] src_addr,
    input  logic [ADDR_SIZE-1:0] dst_addr,
    input  logic [ADDR_SIZE:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] dout_a,
    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    output logic [DATA_SIZE-1:0] din_b
);

    localparam logic [ADDR_SIZE+1:0] RAM_LIMIT = (ADDR_SIZE+2)'(RAM_SIZE);

    dpr_state_t state, next_state;

    logic [ADDR_SIZE+1:0] src_end, dst_end;
    logic                 range_err, descend;
    logic [ADDR_SIZE-1:0] src_first, dst_first;
    logic [ADDR_SIZE-1:0] src_cur, dst_cur;
    logic                 src_last, dst_last;
    logic                 load, run;
    logic                 wr_valid;
    logic [ADDR_SIZE-1:0] wr_addr;

    // One bit of headroom beyond len so a full-RAM range still compares correctly.
    assign src_end = {2'b00, src_addr} + {1'b0, len};
    assign dst_end = {2'b00, dst_addr} + {1'b0, len};

    always_comb begin
        range_err = (src_end > RAM_LIMIT) || (dst_end > RAM_LIMIT);
        descend   = (dst_addr > src_addr) && ({2'b00, dst_addr} < src_end);
        src_first = descend ? src_end[ADDR_SIZE-1:0] - ADDR_SIZE'(1) : src_addr;
        dst_first = descend ? dst_end[ADDR_SIZE-1:0] - ADDR_SIZE'(1) : dst_addr;
    end

    dpr_copy_engine_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_src_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .step       (run),
        .down       (descend),
        .first_addr (src_first),
        .count      (len),
        .addr       (src_cur),
        .last       (src_last)
    );

    dpr_copy_engine_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_dst_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .step       (run),
        .down       (descend),
        .first_addr (dst_first),
        .count      (len),
        .addr       (dst_cur),
        .last       (dst_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
        end else begin
            state    <= next_state;
            wr_valid <= run;
            if (run) begin
                wr_addr <= dst_cur;
            end
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (range_err) begin
                        next_state = ST_ERR;
                    end else if (len == '0) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_RUN;
                        load       = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (src_last && dst_last) begin
                    next_state = ST_LAST;
                end
            end
            ST_LAST: begin
                busy       = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            ST_ERR: begin
                err        = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Port B trails port A by the one-cycle RAM read latency.
    always_comb begin
        run    = (state == ST_RUN);
        en_a   = run;
        we_a   = 1'b0;
        addr_a = run ? src_cur : '0;
        din_a  = '0;
        en_b   = wr_valid;
        we_b   = wr_valid;
        addr_b = wr_addr;
        din_b  = wr_valid ? dout_a : '0;
    end

endmodule

// File: tb/tb_dpr_copy_engine.sv
// Directed bench for dpr_copy_engine against a behavioural dual-port RAM,
// with a write scoreboard on port B and a shadow RAM for content checks.
module tb_dpr_copy_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] src_addr, dst_addr;
    logic [8:0] len;
    logic       busy, done, err;
    logic       en_a, we_a, en_b, we_b;
    logic [7:0] addr_a, din_a, dout_a, addr_b, din_b;

    logic       bd_en;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int wr_seen;
    int r_done_at, r_err_at, r_busy, r_en, r_dones, r_errs;

    always #5 clk = ~clk;

    dpr_copy_engine #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .en_a     (en_a),
        .we_a     (we_a),
        .addr_a   (addr_a),
        .din_a    (din_a),
        .dout_a   (dout_a),
        .en_b     (en_b),
        .we_b     (we_b),
        .addr_b   (addr_b),
        .din_b    (din_b)
    );

    // RAM model: 1-cycle read latency on port A, plus a backdoor write path.
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        if (en_a) begin
            if (we_a) mem[addr_a] <= din_a;
            dout_a <= mem[addr_a];
        end
        if (en_b && we_b) mem[addr_b] <= din_b;
    end

    function automatic logic [7:0] fill(input int i);
        return 8'((i * 13 + 7) % 256);
    endfunction

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endfunction

    function automatic void mon();
        wr_t e;
        if (en_b && we_b) begin
            wr_seen++;
            chk("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(addr_b), 32'(e.addr));
                chk("wr_data", 32'(din_b), 32'(e.data));
                ref_mem[e.addr] = e.data;
            end
        end
    endfunction

    function automatic void push_copy(input int s, input int d, input int l);
        bit desc;
        int i;
        if (s + l > 256 || d + l > 256) return;
        desc = (d > s) && (d < s + l);
        for (int k = 0; k < l; k++) begin
            i = desc ? l - 1 - k : k;
            sb.push_back('{addr: 8'(d + i), data: ref_mem[s + i]});
        end
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        bd_en   = 1'b1;
        bd_addr = 8'(a);
        bd_data = v;
        @(negedge clk);
        bd_en   = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic do_copy(input int s, input int d, input int l, input int budget, input int restart_at);
        int stop_at;
        push_copy(s, d, l);
        src_addr = 8'(s);
        dst_addr = 8'(d);
        len      = 9'(l);
        start    = 1'b1;
        wr_seen  = 0;
        @(negedge clk);
        start     = 1'b0;
        r_done_at = -1;
        r_err_at  = -1;
        r_busy    = 0;
        r_en      = 0;
        r_dones   = 0;
        r_errs    = 0;
        stop_at   = budget;
        for (int n = 1; n <= budget; n++) begin
            if (n == restart_at) begin
                start    = 1'b1;
                src_addr = 8'h00;
                dst_addr = 8'hA0;
                len      = 9'd2;
            end else begin
                start = 1'b0;
            end
            mon();
            if (busy) r_busy++;
            if (en_a || en_b) r_en++;
            if (done) begin
                r_dones++;
                if (r_done_at < 0) begin r_done_at = n; stop_at = n + 2; end
            end
            if (err) begin
                r_errs++;
                if (r_err_at < 0) begin r_err_at = n; stop_at = n + 2; end
            end
            if (n >= stop_at) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int mism;
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_en_a", 32'(en_a), 32'd0);
        chk("rst_we_a", 32'(we_a), 32'd0);
        chk("rst_en_b", 32'(en_b), 32'd0);
        chk("rst_we_b", 32'(we_b), 32'd0);
        chk("rst_addr_a", 32'(addr_a), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'd0);
        chk("rst_din_b", 32'(din_b), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) poke(i, fill(i));

        // T1 ascending copy
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        do_copy(8'h10, 8'h40, 4, 40, 0);
        chk("t1_done_at", 32'(r_done_at), 32'd6);
        chk("t1_busy_cycles", 32'(r_busy), 32'd5);
        chk("t1_done_pulses", 32'(r_dones), 32'd1);
        chk("t1_writes", 32'(wr_seen), 32'd4);
        chk("t1_ram", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hA1B2C3D4);

        // T2 overlap with destination above source
        poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03); poke(8'h23, 8'h04);
        do_copy(8'h20, 8'h22, 4, 40, 0);
        chk("t2_done_at", 32'(r_done_at), 32'd6);
        chk("t2_ram_lo", {16'h0, mem[8'h20], mem[8'h21]}, 32'h0102);
        chk("t2_ram_hi", {mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25]}, 32'h01020304);

        // T3 overlap with destination below source
        do_copy(8'h22, 8'h20, 4, 40, 0);
        chk("t3_done_at", 32'(r_done_at), 32'd6);
        chk("t3_ram", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h01020304);

        // T4 range rejections, zero length, and exact top-of-RAM range
        do_copy(8'hFE, 8'h00, 3, 20, 0);
        chk("t4_err_at", 32'(r_err_at), 32'd1);
        chk("t4_err_pulses", 32'(r_errs), 32'd1);
        chk("t4_err_busy", 32'(r_busy), 32'd0);
        chk("t4_err_access", 32'(r_en), 32'd0);
        chk("t4_err_done", 32'(r_dones), 32'd0);
        do_copy(8'h00, 8'hFF, 2, 20, 0);
        chk("t4_dst_err_at", 32'(r_err_at), 32'd1);
        chk("t4_dst_err_access", 32'(r_en), 32'd0);
        do_copy(8'hFE, 8'h10, 0, 20, 0);
        chk("t4_len0_done_at", 32'(r_done_at), 32'd1);
        chk("t4_len0_access", 32'(r_en), 32'd0);
        chk("t4_len0_busy", 32'(r_busy), 32'd0);
        chk("t4_len0_err", 32'(r_errs), 32'd0);
        do_copy(8'hFC, 8'h80, 4, 40, 0);
        chk("t4_edge_done_at", 32'(r_done_at), 32'd6);
        chk("t4_edge_err", 32'(r_errs), 32'd0);
        chk("t4_edge_ram", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]},
            {fill(252), fill(253), fill(254), fill(255)});

        // T5a second start while busy is dropped
        for (int i = 0; i < 8; i++) poke(8'h60 + i, 8'(8'h80 + i));
        do_copy(8'h60, 8'h90, 8, 60, 3);
        chk("t5_done_at", 32'(r_done_at), 32'd10);
        chk("t5_done_pulses", 32'(r_dones), 32'd1);
        chk("t5_busy_cycles", 32'(r_busy), 32'd9);
        chk("t5_writes", 32'(wr_seen), 32'd8);

        // T5b reset mid-copy aborts without resuming
        for (int i = 0; i < 8; i++) poke(8'h70 + i, 8'(8'h90 + i));
        push_copy(8'h70, 8'hC0, 8);
        src_addr = 8'h70; dst_addr = 8'hC0; len = 9'd8; start = 1'b1; wr_seen = 0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            mon();
            if (n == 4) rst_n = 1'b0;
            else @(negedge clk);
        end
        @(negedge clk);
        mon();
        chk("t5r_en_b", 32'(en_b), 32'd0);
        chk("t5r_en_a", 32'(en_a), 32'd0);
        chk("t5r_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        chk("t5r_writes", 32'(wr_seen), 32'd3);
        sb.delete();
        chk("t5r_ram_copied", {8'h0, mem[8'hC0], mem[8'hC1], mem[8'hC2]}, 32'h00909192);
        chk("t5r_ram_untouched", 32'(mem[8'hC3]), 32'(fill(8'hC3)));
        repeat (3) begin
            @(negedge clk);
            mon();
        end
        chk("t5r_idle_busy", 32'(busy), 32'd0);

        // T6 full-RAM in-place copy
        do_copy(0, 0, 256, 400, 0);
        chk("t6_done_at", 32'(r_done_at), 32'd258);
        chk("t6_busy_cycles", 32'(r_busy), 32'd257);
        chk("t6_writes", 32'(wr_seen), 32'd256);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("t6_ram_image", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
